// File: rtl/sdu_seq_ctrl.sv
// Acquisition sequencer: fires the pulser, times the record window, repeats for the
// averaging count, then waits out receiver playback. Optional build macro: SDU_EXT_TRIG_EN.
module sdu_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_num_seq,
  input  logic [CNT_W-1:0] cfg_rec_len,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic             ext_trig,
  input  logic             sdu_rx_strobe,
  output logic             tx_fire,
  output logic             sdu_rx_en,
  output logic             sdu_seq_done_strobe,
  output logic             sdu_ave_done_strobe,
  output logic             busy,
  output logic [CNT_W-1:0] seq_count,
  output logic             acq_done,
  output logic             cfg_err,
  output logic             aborted
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FIRE, S_RECORD, S_GAP, S_PLAY} state_t;

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_num_seq, r_rec_len, r_gap, r_rcnt, r_seq_cnt;
  logic [CNT_W:0]   r_gcnt;
  logic             r_seen_hi, r_abort_pend;
  logic             r_fire, r_seq_done, r_ave_done, r_busy, r_acq, r_err, r_aborted;

  logic w_fire, w_seq_done, w_ave_done, w_acq, w_err;
  logic w_set_abort, w_clr_abort, w_latch, w_ld_rec, w_ld_gap, w_inc_seq, w_pend_set;
  logic w_term, w_last;
  logic [CNT_W-1:0] w_rec_src;

`ifdef SDU_EXT_TRIG_EN
  logic r_trig_s1, r_trig_s2, r_trig_d;
  logic w_trig_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_trig_d  <= 1'b0;
    end else begin
      r_trig_s1 <= ext_trig;
      r_trig_s2 <= r_trig_s1;
      r_trig_d  <= r_trig_s2;
    end
  end

  assign w_trig_edge = r_trig_s2 & ~r_trig_d;
`else
  logic w_unused_trig;
  assign w_unused_trig = ext_trig;
`endif

  // Counter holds rec_len at FIRE; terminal at 1 puts the done strobe on T+rec_len.
  assign w_term    = (r_rcnt == CNT_W'(1));
  assign w_last    = (({1'b0, r_seq_cnt} + (CNT_W+1)'(1)) == {1'b0, r_num_seq});
  assign w_rec_src = (r_state == S_IDLE) ? cfg_rec_len : r_rec_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_fire      = 1'b0;
    w_seq_done  = 1'b0;
    w_ave_done  = 1'b0;
    w_acq       = 1'b0;
    w_err       = 1'b0;
    w_set_abort = 1'b0;
    w_clr_abort = 1'b0;
    w_latch     = 1'b0;
    w_ld_rec    = 1'b0;
    w_ld_gap    = 1'b0;
    w_inc_seq   = 1'b0;
    w_pend_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_rec_len != '0) begin
            w_latch     = 1'b1;
            w_clr_abort = 1'b1;
`ifdef SDU_EXT_TRIG_EN
            w_nxt       = S_WAIT;
`else
            w_nxt       = S_FIRE;
            w_fire      = 1'b1;
            w_ld_rec    = 1'b1;
`endif
          end else begin
            w_err = 1'b1;
          end
        end
      end
`ifdef SDU_EXT_TRIG_EN
      S_WAIT: begin
        if (cfg_abort) begin
          w_set_abort = 1'b1;
          w_nxt       = S_IDLE;
        end else if (w_trig_edge) begin
          w_nxt    = S_FIRE;
          w_fire   = 1'b1;
          w_ld_rec = 1'b1;
        end
      end
`endif
      S_FIRE, S_RECORD: begin
        if (w_term) begin
          // Terminal count wins over abort; a coincident abort is replayed next cycle.
          w_inc_seq  = 1'b1;
          w_pend_set = cfg_abort;
          if (w_last) begin
            w_ave_done = 1'b1;
            w_nxt      = S_PLAY;
          end else begin
            w_seq_done = 1'b1;
            w_ld_gap   = 1'b1;
            w_nxt      = S_GAP;
          end
        end else if (cfg_abort) begin
          w_seq_done  = 1'b1;
          w_set_abort = 1'b1;
          w_nxt       = S_IDLE;
        end else begin
          w_nxt = S_RECORD;
        end
      end
      S_GAP: begin
        if (cfg_abort || r_abort_pend) begin
          w_set_abort = 1'b1;
          w_nxt       = S_IDLE;
        end else if (r_gcnt == '0) begin
`ifdef SDU_EXT_TRIG_EN
          w_nxt    = S_WAIT;
`else
          w_nxt    = S_FIRE;
          w_fire   = 1'b1;
          w_ld_rec = 1'b1;
`endif
        end
      end
      S_PLAY: begin
        if (r_seen_hi && !sdu_rx_strobe) begin
          w_acq = 1'b1;
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num_seq    <= '0;
      r_rec_len    <= '0;
      r_gap        <= '0;
      r_rcnt       <= '0;
      r_gcnt       <= '0;
      r_seq_cnt    <= '0;
      r_seen_hi    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_fire       <= 1'b0;
      r_seq_done   <= 1'b0;
      r_ave_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_acq        <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      if (w_latch) begin
        r_num_seq <= (cfg_num_seq == '0) ? CNT_W'(1) : cfg_num_seq;
        r_rec_len <= cfg_rec_len;
        r_gap     <= cfg_gap;
      end
      if (w_ld_rec)
        r_rcnt <= w_rec_src;
      else if ((r_state == S_FIRE || r_state == S_RECORD) && r_rcnt != '0)
        r_rcnt <= r_rcnt - CNT_W'(1);
      // GAP lasts gap+2 cycles counting the seq_done cycle itself.
      if (w_ld_gap)
        r_gcnt <= {1'b0, r_gap} + (CNT_W+1)'(1);
      else if (r_state == S_GAP && r_gcnt != '0)
        r_gcnt <= r_gcnt - (CNT_W+1)'(1);
      if (w_latch)        r_seq_cnt <= '0;
      else if (w_inc_seq) r_seq_cnt <= r_seq_cnt + CNT_W'(1);
      r_seen_hi    <= (r_state == S_PLAY) && (r_seen_hi || sdu_rx_strobe);
      r_abort_pend <= w_pend_set;
      r_fire       <= w_fire;
      r_seq_done   <= w_seq_done;
      r_ave_done   <= w_ave_done;
      r_busy       <= (w_nxt != S_IDLE);
      r_acq        <= w_acq;
      r_err        <= w_err;
      if (w_clr_abort)      r_aborted <= 1'b0;
      else if (w_set_abort) r_aborted <= 1'b1;
    end
  end

  assign tx_fire             = r_fire;
  assign sdu_rx_en           = r_fire;
  assign sdu_seq_done_strobe = r_seq_done;
  assign sdu_ave_done_strobe = r_ave_done;
  assign busy                = r_busy;
  assign seq_count           = r_seq_cnt;
  assign acq_done            = r_acq;
  assign cfg_err             = r_err;
  assign aborted             = r_aborted;

endmodule

// File: tb/tb_sdu_seq_ctrl.sv
// Directed bench for sdu_seq_ctrl: a vector table of whole runs plus hand-built
// abort / overlap / reset / external-trigger sequences, all timed against the first fire.
module tb_sdu_seq_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [CNT_W-1:0] cfg_num_seq = '0, cfg_rec_len = '0, cfg_gap = '0;
  logic             ext_trig = 1'b0, sdu_rx_strobe = 1'b0;
  logic             tx_fire, sdu_rx_en, sdu_seq_done_strobe, sdu_ave_done_strobe, busy;
  logic [CNT_W-1:0] seq_count;
  logic             acq_done, cfg_err, aborted;

  sdu_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_seq(cfg_num_seq), .cfg_rec_len(cfg_rec_len), .cfg_gap(cfg_gap),
    .ext_trig(ext_trig), .sdu_rx_strobe(sdu_rx_strobe),
    .tx_fire(tx_fire), .sdu_rx_en(sdu_rx_en), .sdu_seq_done_strobe(sdu_seq_done_strobe),
    .sdu_ave_done_strobe(sdu_ave_done_strobe), .busy(busy), .seq_count(seq_count),
    .acq_done(acq_done), .cfg_err(cfg_err), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_fire[$], q_seq[$], q_ave[$], q_acq[$];
  int n_err = 0, n_busy = 0, n_rxen_mis = 0;

  always @(negedge clk) begin
    if (tx_fire)             q_fire.push_back(cyc);
    if (sdu_seq_done_strobe) q_seq.push_back(cyc);
    if (sdu_ave_done_strobe) q_ave.push_back(cyc);
    if (acq_done)            q_acq.push_back(cyc);
    if (cfg_err)             n_err++;
    if (busy)                n_busy++;
    if (tx_fire != sdu_rx_en) n_rxen_mis++;
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic clr_log();
    q_fire.delete(); q_seq.delete(); q_ave.delete(); q_acq.delete();
    n_err = 0; n_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Leaves the bench in the first cycle after the start strobe was sampled.
  task automatic start(input int ns, input int rl, input int gp);
    tick();
    cfg_num_seq = CNT_W'(ns); cfg_rec_len = CNT_W'(rl); cfg_gap = CNT_W'(gp);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Runs until the block idles, answering ave_done with a slen-cycle playback burst.
  task automatic play_out(input int slen);
    int k = 0, sc = -1;
    while (k < 3000) begin
      tick(); k++;
      if (sc < 0 && q_ave.size() > 0) sc = 0;
      if (sc >= 0 && sc < slen) begin sdu_rx_strobe = 1'b1; sc++; end
      else sdu_rx_strobe = 1'b0;
      if (!busy && k > 1) break;
    end
    sdu_rx_strobe = 1'b0;
    chk("run_timeout", int'(k < 3000), 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_fires(input int n);
    int k = 0;
    while (q_fire.size() < n && k < 200) begin tick(); k++; end
    chk("wait_fire", int'(k < 200), 1);
  endtask

  typedef struct {
    int ns, rl, gp, slen;
    int nfire, fire2, nseq, seq1, ave, acq, cnt, err;
  } vec_t;

  initial begin
    vec_t v[4];
    int   e;

    v[0] = '{ns:1, rl:0, gp:2, slen:8, nfire:0, fire2:-1, nseq:0, seq1:-1, ave:-1, acq:-1, cnt:0, err:1};
    v[1] = '{ns:3, rl:8, gp:4, slen:8, nfire:3, fire2:14, nseq:2, seq1:8,  ave:36, acq:46, cnt:3, err:0};
    v[2] = '{ns:0, rl:5, gp:3, slen:3, nfire:1, fire2:-1, nseq:0, seq1:-1, ave:5,  acq:10, cnt:1, err:0};
    v[3] = '{ns:2, rl:1, gp:0, slen:2, nfire:2, fire2:3,  nseq:1, seq1:1,  ave:4,  acq:8,  cnt:2, err:0};

    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_seq_count", int'(seq_count), 0);
    chk("rst_strobes", int'({tx_fire, sdu_rx_en, sdu_seq_done_strobe, sdu_ave_done_strobe}), 0);
    chk("rst_flags", int'({acq_done, cfg_err, aborted}), 0);
    reset_n = 1'b1;
    tick();

    // An abort in IDLE without a start must leave nothing behind.
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0; tick();
    chk("idle_abort", int'({busy, aborted}), 0);

`ifndef SDU_EXT_TRIG_EN
    for (int i = 0; i < 4; i++) begin
      clr_log();
      start(v[i].ns, v[i].rl, v[i].gp);
      play_out(v[i].slen);
      chk($sformatf("v%0d_nfire", i), q_fire.size(), v[i].nfire);
      chk($sformatf("v%0d_nseq", i), q_seq.size(), v[i].nseq);
      chk($sformatf("v%0d_nave", i), q_ave.size(), (v[i].ave >= 0) ? 1 : 0);
      chk($sformatf("v%0d_nacq", i), q_acq.size(), (v[i].acq >= 0) ? 1 : 0);
      chk($sformatf("v%0d_cfg_err", i), n_err, v[i].err);
      chk($sformatf("v%0d_seq_count", i), int'(seq_count), v[i].cnt);
      chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
      if (v[i].nfire == 0) chk($sformatf("v%0d_busy_never", i), n_busy, 0);
      if (q_fire.size() > 0) begin
        if (v[i].fire2 >= 0 && q_fire.size() > 1)
          chk($sformatf("v%0d_fire2_t", i), q_fire[1] - q_fire[0], v[i].fire2);
        if (v[i].nfire == 3 && q_fire.size() > 2)
          chk($sformatf("v%0d_fire3_t", i), q_fire[2] - q_fire[0], 2 * v[i].fire2);
        if (v[i].seq1 >= 0 && q_seq.size() > 0)
          chk($sformatf("v%0d_seq1_t", i), q_seq[0] - q_fire[0], v[i].seq1);
        if (q_ave.size() > 0)
          chk($sformatf("v%0d_ave_t", i), q_ave[0] - q_fire[0], v[i].ave);
        if (q_acq.size() > 0)
          chk($sformatf("v%0d_acq_t", i), q_acq[0] - q_fire[0], v[i].acq);
      end
    end

    // Abort three cycles into the second RECORD.
    clr_log();
    start(3, 8, 4);
    wait_fires(2);
    tick(); tick();
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    repeat (4) tick();
    chk("ab_nseq", q_seq.size(), 2);
    if (q_seq.size() > 1) chk("ab_seq_t", q_seq[1] - q_fire[0], 18);
    chk("ab_nave", q_ave.size(), 0);
    chk("ab_aborted", int'(aborted), 1);
    chk("ab_busy", int'(busy), 0);
    chk("ab_seq_count", int'(seq_count), 1);
    clr_log();
    start(1, 2, 0);
    play_out(2);
    chk("ab_restart_aborted", int'(aborted), 0);
    chk("ab_restart_acq", q_acq.size(), 1);

    // Abort coincident with the terminal count: strobe first, then abort out of GAP.
    clr_log();
    start(3, 4, 5);
    repeat (3) tick();
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    repeat (12) tick();
    chk("tc_nfire", q_fire.size(), 1);
    chk("tc_nseq", q_seq.size(), 1);
    if (q_seq.size() > 0) chk("tc_seq_t", q_seq[0] - q_fire[0], 4);
    chk("tc_aborted", int'(aborted), 1);
    chk("tc_seq_count", int'(seq_count), 1);
    chk("tc_busy", int'(busy), 0);

    // Start during RECORD and abort during PLAYBACK are both ignored.
    clr_log();
    start(2, 6, 1);
    tick(); tick();
    cfg_start = 1'b1; cfg_rec_len = '0; cfg_num_seq = 16'd5; tick(); cfg_start = 1'b0;
    begin
      int k = 0;
      while (q_ave.size() == 0 && k < 200) begin tick(); k++; end
      chk("ov_wait_ave", int'(k < 200), 1);
    end
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    play_out(4);
    if (q_fire.size() > 1) chk("ov_fire2_t", q_fire[1] - q_fire[0], 9);
    chk("ov_nfire", q_fire.size(), 2);
    chk("ov_nacq", q_acq.size(), 1);
    chk("ov_cfg_err", n_err, 0);
    chk("ov_aborted", int'(aborted), 0);
    chk("ov_seq_count", int'(seq_count), 2);
`else
    // External trigger, gap=0: fire 3 cycles after an edge; edges during GAP are dropped.
    clr_log();
    start(2, 3, 0);
    repeat (10) tick();
    chk("et_no_fire", q_fire.size(), 0);
    chk("et_busy_wait", int'(busy), 1);
    e = cyc;
    ext_trig = 1'b1; tick(); ext_trig = 1'b0;
    wait_fires(1);
    if (q_fire.size() > 0) chk("et_fire1_t", q_fire[0] - e, 3);
    ext_trig = 1'b1; tick(); ext_trig = 1'b0;
    repeat (10) tick();
    chk("et_gap_edge_ignored", q_fire.size(), 1);
    chk("et_nseq", q_seq.size(), 1);
    e = cyc;
    ext_trig = 1'b1; tick(); ext_trig = 1'b0;
    wait_fires(2);
    if (q_fire.size() > 1) chk("et_fire2_t", q_fire[1] - e, 3);
    play_out(3);
    chk("et_nave", q_ave.size(), 1);
    if (q_ave.size() > 0 && q_fire.size() > 1) chk("et_ave_t", q_ave[0] - q_fire[1], 3);
    chk("et_nacq", q_acq.size(), 1);
    chk("et_seq_count", int'(seq_count), 2);
`endif

    // Asynchronous reset mid-run clears everything without a clock edge.
    clr_log();
    start(1, 10, 0);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_seq_count", int'(seq_count), 0);
    chk("arst_strobes", int'({tx_fire, sdu_seq_done_strobe, sdu_ave_done_strobe, acq_done}), 0);
    repeat (3) tick();
    chk("arst_no_strobe", q_seq.size() + q_ave.size() + q_acq.size(), 0);
    reset_n = 1'b1;
    tick();

    chk("rx_en_matches_fire", n_rxen_mis, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sdu_seq_ctrl.md
Name: sdu_seq_ctrl

Overview:
Acquisition sequencer for the SDUltrasound averaging receiver. It fires the pulser and opens the receiver record window for a programmed number of samples. It repeats this for a programmed number of acquisitions, then waits for the receiver's playback burst to the host to finish. It generates the sdu_rx_en, sdu_seq_done_strobe and sdu_ave_done_strobe controls, and takes its configuration from the settings bus.

Parameters:
CNT_W, 16, width of the acquisition count, record length and gap counters.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle start strobe; latches cfg_* values
cfg_abort  in  1  one-cycle abort strobe
cfg_num_seq  in  CNT_W  acquisitions to average; 0 is treated as 1
cfg_rec_len  in  CNT_W  samples per acquisition
cfg_gap  in  CNT_W  idle cycles between acquisitions (ring-down)
ext_trig  in  1  external trigger; used only with SDU_EXT_TRIG_EN
sdu_rx_strobe  in  1  receiver playback data strobe
tx_fire  out  1  one-cycle pulser trigger
sdu_rx_en  out  1  one-cycle receiver record start
sdu_seq_done_strobe  out  1  end of a non-final acquisition
sdu_ave_done_strobe  out  1  end of the final acquisition
busy  out  1  high in any state other than IDLE
seq_count  out  CNT_W  acquisitions completed in the current run
acq_done  out  1  one-cycle pulse when playback completes
cfg_err  out  1  one-cycle pulse when a start is rejected
aborted  out  1  sticky; set by abort, cleared by the next accepted start

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE. All outputs 0; seq_count 0; counters 0.
- All outputs are registered. Strobes are exactly one cycle wide.
- Start handling:
  - cfg_start in IDLE with cfg_rec_len != 0: latch num_seq, rec_len and gap; clear seq_count and aborted; go to FIRE.
  - cfg_start in IDLE with cfg_rec_len == 0: pulse cfg_err; stay in IDLE.
  - cfg_start while busy: ignored, no cfg_err.
- FIRE (1 cycle): tx_fire=1 and sdu_rx_en=1 on the same cycle (call it cycle T). Load the record counter; go to RECORD.
- RECORD:
  - The record counter counts down.
  - The done strobe is asserted on cycle T+rec_len, so the receiver records exactly rec_len samples.
  - If seq_count+1 == num_seq: pulse sdu_ave_done_strobe and go to PLAYBACK.
  - Otherwise: pulse sdu_seq_done_strobe and go to GAP.
  - seq_count increments on the same cycle as the done strobe.
- GAP:
  - Hold for gap+2 cycles, so the next FIRE occurs at least 2 cycles after seq_done while the receiver passes through its SEQ_DONE and RESET states.
  - gap == 0 therefore yields a 2-cycle gap. Then go to FIRE.
- PLAYBACK:
  - Wait for sdu_rx_strobe to be seen high and then low.
  - On that falling edge, pulse acq_done and go to IDLE.
  - sdu_rx_strobe outside PLAYBACK is ignored.
- Abort:
  - In FIRE or RECORD: pulse sdu_seq_done_strobe (never ave_done) on the next cycle so the receiver returns to reset; set aborted; go to IDLE.
  - In GAP: set aborted; go to IDLE immediately.
  - In PLAYBACK: ignored; playback completes normally.
  - In IDLE: no effect.
- Simultaneous events:
  - Abort on the same cycle as the RECORD terminal count: the terminal strobe is issued as normal, and the abort is then handled from the resulting state.
  - cfg_start together with cfg_abort in IDLE: start wins.
- Counter arithmetic is unsigned, CNT_W bits, with no wrap. num_seq = 2^CNT_W-1 is legal.
- Asserting reset mid-run returns the block to IDLE asynchronously with no strobes issued.

Optional Feature:
SDU_EXT_TRIG_EN:
- When defined, FIRE is entered from the start and from GAP only on a rising edge of ext_trig. ext_trig is synchronised through 2 flops; edge detection occurs after the synchroniser.
- The GAP minimum of gap+2 cycles still applies, and trigger edges during GAP are discarded.
- When not defined, ext_trig is unused and FIRE follows GAP timing directly.

Test Plan:
- Basic run, rec_len=8, num_seq=3, gap=4:
  - tx_fire/sdu_rx_en at T, T+14, T+28.
  - sdu_seq_done_strobe at T+8 and T+22; sdu_ave_done_strobe at T+36; seq_count ends at 3.
  - Inject sdu_rx_strobe high for 8 cycles, then low: acq_done 1 cycle after the fall; busy drops.
- num_seq=0, rec_len=5: one acquisition only; sdu_ave_done_strobe at T+5; no seq_done.
- rec_len=0 start: cfg_err pulses once; busy stays 0; no tx_fire.
- Abort 3 cycles into RECORD of the 2nd acquisition:
  - sdu_seq_done_strobe on the next cycle; aborted=1; IDLE; no ave_done.
  - A following valid start clears aborted.
- cfg_start during RECORD and cfg_abort during PLAYBACK: both ignored; the run completes with acq_done.
- With SDU_EXT_TRIG_EN, gap=0:
  - No tx_fire until an ext_trig rising edge; fire occurs 3 cycles after the edge.
  - A trigger edge arriving during GAP does not fire; the next edge does.
